// File: rtl/mem_stage_rx.sv
// Memory-access pipeline stage: waits for data-SRAM responses, aligns load data,
// drops responses owned by flushed bundles and hands completed bundles to WB.
module mem_stage_rx #(
  parameter int PASS_WD         = 67,
  parameter int ES_TO_MS_BUS_WD = 107 + PASS_WD,
  parameter int MS_TO_WS_BUS_WD = 70 + PASS_WD
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       flush,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_fwd_valid,
  output logic [4:0]                 ms_fwd_dest,
  output logic [31:0]                ms_fwd_data,
  output logic                       ms_fwd_block
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_LWL = 3'd5;
  localparam logic [2:0] OP_LWR = 3'd6;

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic [1:0]                 state;
  logic [31:0]                rdata_buf;
  logic [1:0]                 discard_cnt;

  logic [31:0]        pc;
  logic [31:0]        alu_result;
  logic [4:0]         dest;
  logic               gr_we;
  logic               is_load;
  logic [2:0]         load_op;
  logic [31:0]        rt_value;
  logic [PASS_WD-1:0] pass;

  assign pc         = bus_r[31:0];
  assign alu_result = bus_r[63:32];
  assign dest       = bus_r[68:64];
  assign gr_we      = bus_r[69];
  assign is_load    = bus_r[71];
  assign load_op    = bus_r[74:72];
  assign rt_value   = bus_r[106:75];
  assign pass       = bus_r[106+PASS_WD:107];

  logic ms_ready_go;
  logic accept;
  logic in_mem_req;
  logic drop_ok;
  logic wait_done;
  logic leaving;
  logic [1:0] pending_inc;
  logic [1:0] launch_inc;

  assign in_mem_req  = es_to_ms_bus[70];
  assign ms_ready_go = (state == READY);
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign accept      = es_to_ms_valid && ms_allowin && !flush;
  assign leaving     = ms_valid && ms_ready_go && ws_allowin;
  assign drop_ok     = data_sram_data_ok && (discard_cnt != 2'd0);
  assign wait_done   = data_sram_data_ok && (discard_cnt == 2'd0) && (state == WAIT);

  // A flushed WAIT whose response lands in the same cycle owes nothing further.
  assign pending_inc = {1'b0, (state == WAIT) && !wait_done};
  assign launch_inc  = {1'b0, es_to_ms_valid && ms_allowin && in_mem_req};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid    <= 1'b0;
      bus_r       <= '0;
      state       <= EMPTY;
      rdata_buf   <= 32'd0;
      discard_cnt <= 2'd0;
    end else if (flush) begin
      ms_valid    <= 1'b0;
      state       <= EMPTY;
      discard_cnt <= discard_cnt + pending_inc + launch_inc - {1'b0, drop_ok};
    end else begin
      if (drop_ok) begin
        discard_cnt <= discard_cnt - 2'd1;
      end else if (wait_done) begin
        rdata_buf <= data_sram_rdata;
        state     <= READY;
      end
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (accept) begin
        bus_r <= es_to_ms_bus;
        state <= in_mem_req ? WAIT : READY;
      end else if (leaving) begin
        state <= EMPTY;
      end
    end
  end

  logic [31:0] load_data;
  logic [31:0] final_result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte   = rdata_buf[7:0];
    ld_half   = alu_result[1] ? rdata_buf[31:16] : rdata_buf[15:0];
    load_data = rdata_buf;
    case (alu_result[1:0])
      2'd0:    ld_byte = rdata_buf[7:0];
      2'd1:    ld_byte = rdata_buf[15:8];
      2'd2:    ld_byte = rdata_buf[23:16];
      default: ld_byte = rdata_buf[31:24];
    endcase
    case (load_op)
      OP_LW:  load_data = rdata_buf;
      OP_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: load_data = {24'd0, ld_byte};
      OP_LH:  load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU: load_data = {16'd0, ld_half};
      OP_LWL: begin
        case (alu_result[1:0])
          2'd0:    load_data = {rdata_buf[7:0],  rt_value[23:0]};
          2'd1:    load_data = {rdata_buf[15:0], rt_value[15:0]};
          2'd2:    load_data = {rdata_buf[23:0], rt_value[7:0]};
          default: load_data = rdata_buf;
        endcase
      end
      OP_LWR: begin
        case (alu_result[1:0])
          2'd0:    load_data = rdata_buf;
          2'd1:    load_data = {rt_value[31:24], rdata_buf[31:8]};
          2'd2:    load_data = {rt_value[31:16], rdata_buf[31:16]};
          default: load_data = {rt_value[31:8],  rdata_buf[31:24]};
        endcase
      end
      default: load_data = rdata_buf;
    endcase
    final_result = is_load ? load_data : alu_result;
  end

  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign ms_to_ws_bus   = {pass, gr_we, dest, final_result, pc};

  assign ms_fwd_valid = ms_valid && gr_we;
  assign ms_fwd_dest  = dest;
  assign ms_fwd_data  = final_result;
  assign ms_fwd_block = ms_fwd_valid && is_load && (state != READY);

endmodule

// File: tb/tb_mem_stage_rx.sv
// Directed bench for mem_stage_rx: ALU pass-through, load alignment, stores,
// WB back-pressure, flush discard and asynchronous reset.
module tb_mem_stage_rx;
  localparam int PASS_WD = 67;
  localparam int ES_WD   = 107 + PASS_WD;
  localparam int WS_WD   = 70 + PASS_WD;

  logic             clk = 1'b0;
  logic             resetn;
  logic             es_to_ms_valid;
  logic [ES_WD-1:0] es_to_ms_bus;
  logic             ms_allowin;
  logic             ws_allowin;
  logic             ms_to_ws_valid;
  logic [WS_WD-1:0] ms_to_ws_bus;
  logic             flush;
  logic             data_sram_data_ok;
  logic [31:0]      data_sram_rdata;
  logic             ms_fwd_valid;
  logic [4:0]       ms_fwd_dest;
  logic [31:0]      ms_fwd_data;
  logic             ms_fwd_block;

  int total = 0;
  int bad   = 0;

  mem_stage_rx #(.PASS_WD(PASS_WD)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .flush             (flush),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_fwd_valid      (ms_fwd_valid),
    .ms_fwd_dest       (ms_fwd_dest),
    .ms_fwd_data       (ms_fwd_data),
    .ms_fwd_block      (ms_fwd_block)
  );

  always #5 clk = ~clk;

  function automatic logic [ES_WD-1:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                          input logic [4:0] dest, input logic we,
                                          input logic mreq, input logic ld,
                                          input logic [2:0] op, input logic [31:0] rt,
                                          input logic [PASS_WD-1:0] pass);
    return {pass, rt, op, ld, mreq, we, dest, alu, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    #2;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ms_to_ws_valid); end
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b want=1", ms_allowin); end
    total++; if (ms_fwd_valid !== 1'b0 || ms_fwd_block !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%b%b want=00", ms_fwd_valid, ms_fwd_block); end
    total++; if (ms_to_ws_bus !== '0) begin bad++; $display("FAIL reset_bus got=%h want=0", ms_to_ws_bus); end
    step(); step();
    resetn = 1'b1;
    step();
    $display("reset: allowin=%b valid=%b", ms_allowin, ms_to_ws_valid);
  endtask

  task automatic test_alu();
    logic [PASS_WD-1:0] pv;
    pv = 67'h5_A5A5_A5A5_1234_5678;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'hBFC0_0000, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 32'hFFFF_FFFF, pv);
    step();
    es_to_ms_valid = 1'b0;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%b want=1", ms_to_ws_valid); end
    total++; if (ms_to_ws_bus[63:32] !== 32'h0000_1234) begin bad++; $display("FAIL alu_result got=%h want=00001234", ms_to_ws_bus[63:32]); end
    total++; if (ms_to_ws_bus[31:0] !== 32'hBFC0_0000 || ms_to_ws_bus[68:64] !== 5'd5 || ms_to_ws_bus[69] !== 1'b1) begin
      bad++; $display("FAIL alu_fields got pc=%h dest=%0d we=%b want pc=bfc00000 dest=5 we=1", ms_to_ws_bus[31:0], ms_to_ws_bus[68:64], ms_to_ws_bus[69]);
    end
    total++; if (ms_to_ws_bus[136:70] !== pv) begin bad++; $display("FAIL alu_pass got=%h want=%h", ms_to_ws_bus[136:70], pv); end
    total++; if (ms_fwd_valid !== 1'b1 || ms_fwd_block !== 1'b0 || ms_fwd_dest !== 5'd5 || ms_fwd_data !== 32'h1234) begin
      bad++; $display("FAIL alu_fwd got v=%b b=%b d=%0d data=%h want 1 0 5 00001234", ms_fwd_valid, ms_fwd_block, ms_fwd_dest, ms_fwd_data);
    end
    $display("alu: pc=%h result=%h", ms_to_ws_bus[31:0], ms_to_ws_bus[63:32]);
    step();
    total++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin bad++; $display("FAIL alu_drain got v=%b a=%b want 0 1", ms_to_ws_valid, ms_allowin); end
  endtask

  task automatic run_load(input string nm, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'hBFC0_0100, addr, 5'd9, 1'b1, 1'b1, 1'b1, op, rt, '0);
    step();
    es_to_ms_valid = 1'b0;
    total++; if (ms_fwd_block !== 1'b1 || ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL %s_wait got block=%b valid=%b want 1 0", nm, ms_fwd_block, ms_to_ws_valid); end
    step(); step();
    total++; if (ms_fwd_block !== 1'b1 || ms_allowin !== 1'b0) begin bad++; $display("FAIL %s_hold got block=%b allowin=%b want 1 0", nm, ms_fwd_block, ms_allowin); end
    data_sram_data_ok = 1'b1; data_sram_rdata = rd;
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== exp) begin
      bad++; $display("FAIL %s_result got valid=%b result=%h want 1 %h", nm, ms_to_ws_valid, ms_to_ws_bus[63:32], exp);
    end
    total++; if (ms_fwd_block !== 1'b0 || ms_fwd_data !== exp) begin bad++; $display("FAIL %s_fwd got block=%b data=%h want 0 %h", nm, ms_fwd_block, ms_fwd_data, exp); end
    $display("load %s: addr=%h rdata=%h result=%h", nm, addr, rd, ms_to_ws_bus[63:32]);
    step();
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL %s_drain got=%b want=0", nm, ms_to_ws_valid); end
  endtask

  task automatic test_loads();
    run_load("lb",  3'd1, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 32'hFFFF_FF80);
    run_load("lbu", 3'd2, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 32'h0000_0080);
    run_load("lb1", 3'd1, 32'h0000_1001, 32'h0, 32'h80AA_BBCC, 32'hFFFF_FFBB);
    run_load("lwl", 3'd5, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
    run_load("lwr", 3'd6, 32'h0000_2002, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB);
    run_load("lwr3", 3'd6, 32'h0000_2003, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_33AA);
    run_load("lh",  3'd3, 32'h0000_3002, 32'h0, 32'h8001_1234, 32'hFFFF_8001);
    run_load("lhu", 3'd4, 32'h0000_3000, 32'h0, 32'h0000_F00F, 32'h0000_F00F);
    run_load("lw",  3'd0, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);
  endtask

  task automatic test_store();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'hBFC0_0200, 32'h0000_0100, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h77, '0);
    step();
    es_to_ms_valid = 1'b0;
    total++; if (ms_to_ws_valid !== 1'b0 || ms_fwd_valid !== 1'b0) begin bad++; $display("FAIL store_wait got valid=%b fwd=%b want 0 0", ms_to_ws_valid, ms_fwd_valid); end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1357_9BDF;
    step();
    data_sram_data_ok = 1'b0;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_0100) begin
      bad++; $display("FAIL store_result got valid=%b result=%h want 1 00000100", ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
    $display("store: addr=%h result=%h", 32'h100, ms_to_ws_bus[63:32]);
    step();
  endtask

  task automatic test_ws_stall();
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'hBFC0_0300, 32'h0000_4000, 5'd3, 1'b1, 1'b1, 1'b1, 3'd0, 32'h0, '0);
    step();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_CAFE;
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0BAD_CAFE || ms_allowin !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d got valid=%b result=%h allowin=%b want 1 0badcafe 0", i, ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin);
      end
      step();
    end
    ws_allowin = 1'b1;
    #1;
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL stall_release got allowin=%b want 1", ms_allowin); end
    $display("stall: result=%h emitted after release", ms_to_ws_bus[63:32]);
    step();
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b want=0", ms_to_ws_valid); end
  endtask

  task automatic test_flush();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'hBFC0_0400, 32'h0000_5000, 5'd4, 1'b1, 1'b1, 1'b1, 3'd0, 32'h0, '0);
    step();
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (ms_allowin !== 1'b1 || ms_fwd_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got allowin=%b fwd=%b want 1 0", ms_allowin, ms_fwd_valid); end
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'hBFC0_0404, 32'h0000_0040, 5'd7, 1'b1, 1'b1, 1'b1, 3'd0, 32'h0, '0);
    step();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    step();
    data_sram_data_ok = 1'b0;
    total++; if (ms_to_ws_valid !== 1'b0 || ms_fwd_block !== 1'b1) begin bad++; $display("FAIL flush_drop got valid=%b block=%b want 0 1", ms_to_ws_valid, ms_fwd_block); end
    step();
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL flush_still_wait got=%b want=0", ms_to_ws_valid); end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0005;
    step();
    data_sram_data_ok = 1'b0;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h5 || ms_to_ws_bus[68:64] !== 5'd7) begin
      bad++; $display("FAIL flush_result got valid=%b result=%h dest=%0d want 1 00000005 7", ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ws_bus[68:64]);
    end
    $display("flush: second load result=%h", ms_to_ws_bus[63:32]);
    step();
    // Flush while READY masks the output combinationally.
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'hBFC0_0408, 32'h0000_00AA, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, '0);
    step();
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL flush_mask got=%b want=0", ms_to_ws_valid); end
    step();
    flush = 1'b0; ws_allowin = 1'b1;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin bad++; $display("FAIL flush_ready got v=%b a=%b want 0 1", ms_to_ws_valid, ms_allowin); end
  endtask

  task automatic test_back_to_back();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'hBFC0_0500, 32'h0000_AAAA, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, '0);
    step();
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hAAAA || ms_allowin !== 1'b1) begin
      bad++; $display("FAIL b2b_first got v=%b r=%h a=%b want 1 0000aaaa 1", ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin);
    end
    es_to_ms_bus = mk(32'hBFC0_0504, 32'h0000_BBBB, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, '0);
    step();
    es_to_ms_valid = 1'b0;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hBBBB || ms_to_ws_bus[31:0] !== 32'hBFC0_0504) begin
      bad++; $display("FAIL b2b_second got v=%b r=%h pc=%h want 1 0000bbbb bfc00504", ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ws_bus[31:0]);
    end
    $display("b2b: second result=%h", ms_to_ws_bus[63:32]);
    step();
  endtask

  task automatic test_reset_mid_wait();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'hBFC0_0600, 32'h0000_6000, 5'd6, 1'b1, 1'b1, 1'b1, 3'd0, 32'h0, '0);
    step();
    es_to_ms_valid = 1'b0;
    total++; if (ms_fwd_block !== 1'b1) begin bad++; $display("FAIL rst_pre got block=%b want 1", ms_fwd_block); end
    resetn = 1'b0;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0 || ms_fwd_valid !== 1'b0 || ms_fwd_block !== 1'b0 || ms_to_ws_bus !== '0) begin
      bad++; $display("FAIL rst_mid got v=%b fv=%b fb=%b bus=%h want all zero", ms_to_ws_valid, ms_fwd_valid, ms_fwd_block, ms_to_ws_bus);
    end
    step();
    resetn = 1'b1;
    step();
    total++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL rst_release got a=%b v=%b want 1 0", ms_allowin, ms_to_ws_valid); end
    $display("reset mid-wait: allowin=%b", ms_allowin);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_store();
    test_ws_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
